// File: rtl/hub75_scan.sv
// HUB75 1/16-scan driver for a 32x32 panel fed from the 1024x12 pixel buffer.
// Four binary-weighted bitplanes per row pair give 4-bit colour depth.
module hub75_scan #(
  parameter int COLS      = 32,
  parameter int ROW_PAIRS = 16,
  parameter int BASE_TIME = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic [9:0]  rd_address,
  input  logic [11:0] rd_data,
  output logic        r1,
  output logic        g1,
  output logic        b1,
  output logic        r2,
  output logic        g2,
  output logic        b2,
  output logic [3:0]  row_addr,
  output logic        panel_clk,
  output logic        panel_lat,
  output logic        panel_oe,
  output logic        frame_done
);

  localparam int RW = $clog2(ROW_PAIRS);
  localparam int SW = $clog2(COLS) + 2;
  localparam int DW = $clog2((BASE_TIME << 3) + 1);

  typedef enum logic [2:0] {
    IDLE, SHIFT, BLANK, LATCH, DISPLAY
  } state_e;

  state_e          state_q, state_d;
  logic [RW-1:0]   row_q, row_d;
  logic [1:0]      plane_q, plane_d;
  logic [SW-1:0]   sft_q, sft_d;
  logic [DW-1:0]   dcnt_q, dcnt_d;
  logic [2:0]      up_q, up_d;
  logic [5:0]      pix_q, pix_d;
  logic [3:0]      rowa_q, rowa_d;
  logic            frame_q, frame_d;

  logic [1:0]      ph;
  logic [SW-3:0]   col;
  logic [2:0]      bits;
  int              ra;
  int              dlen;

  assign ph  = sft_q[1:0];
  assign col = sft_q[SW-1:2];

  // Colour bits of the current plane from whatever pixel is on rd_data.
  assign bits = {rd_data[{2'd0, plane_q}],
                 rd_data[4'd4 + {2'd0, plane_q}],
                 rd_data[4'd8 + {2'd0, plane_q}]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      row_q   <= '0;
      plane_q <= '0;
      sft_q   <= '0;
      dcnt_q  <= '0;
      up_q    <= '0;
      pix_q   <= '0;
      rowa_q  <= '0;
      frame_q <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      plane_q <= plane_d;
      sft_q   <= sft_d;
      dcnt_q  <= dcnt_d;
      up_q    <= up_d;
      pix_q   <= pix_d;
      rowa_q  <= rowa_d;
      frame_q <= frame_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    plane_d = plane_q;
    sft_d   = sft_q;
    dcnt_d  = dcnt_q;
    up_d    = up_q;
    pix_d   = pix_q;
    rowa_d  = rowa_q;
    frame_d = 1'b0;
    dlen    = BASE_TIME << plane_q;
    unique case (state_q)
      IDLE: begin
        sft_d  = '0;
        dcnt_d = '0;
        if (enable) state_d = SHIFT;
      end
      SHIFT: begin
        sft_d = sft_q + 1'b1;
        if (ph == 2'd1) up_d = bits;
        if (ph == 2'd2) pix_d = {up_q, bits};
        if (sft_q == '1) state_d = BLANK;
      end
      BLANK: begin
        rowa_d  = 4'(row_q);
        state_d = LATCH;
      end
      LATCH: begin
        dcnt_d  = '0;
        state_d = DISPLAY;
      end
      DISPLAY: begin
        dcnt_d = dcnt_q + 1'b1;
        if (dcnt_q == DW'(dlen - 1)) begin
          dcnt_d  = '0;
          state_d = SHIFT;
          if (plane_q == 2'd3) begin
            plane_d = '0;
            if (row_q == RW'(ROW_PAIRS - 1)) begin
              row_d   = '0;
              frame_d = 1'b1;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            plane_d = plane_q + 1'b1;
          end
          if (!enable) begin
            state_d = IDLE;
            row_d   = '0;
            plane_d = '0;
            pix_d   = '0;
            rowa_d  = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Upper-half pixel is fetched in P0, lower-half from P1 onwards.
  always_comb begin
    ra = int'(row_q);
    if (ph != 2'd0) ra = ra + ROW_PAIRS;
    ra = ra * COLS + int'(col);
    rd_address = (state_q == SHIFT) ? 10'(ra) : 10'd0;
  end

  assign {r1, g1, b1, r2, g2, b2} = pix_q;
  assign row_addr   = rowa_q;
  assign panel_clk  = (state_q == SHIFT) && (ph == 2'd3);
  assign panel_lat  = (state_q == LATCH);
  assign panel_oe   = (state_q != DISPLAY);
  assign frame_done = frame_q;

endmodule

// File: tb/tb_hub75_scan.sv
// Bench for hub75_scan: random buffer contents, per-cycle comparison
// against an arithmetic model of the frame timeline.
module tb_hub75_scan;

  localparam int BT    = 64;
  localparam int ROWC  = 4 * 130 + 15 * BT;
  localparam int FRAME = 16 * ROWC;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic [9:0]  rd_address;
  logic [11:0] rd_data = 12'd0;
  logic        r1, g1, b1, r2, g2, b2;
  logic [3:0]  row_addr;
  logic        panel_clk, panel_lat, panel_oe, frame_done;

  logic [11:0] mem [1024];
  int total = 0;
  int bad = 0;

  hub75_scan dut (
    .clk(clk), .rst(rst), .enable(enable),
    .rd_address(rd_address), .rd_data(rd_data),
    .r1(r1), .g1(g1), .b1(b1), .r2(r2), .g2(g2), .b2(b2),
    .row_addr(row_addr), .panel_clk(panel_clk),
    .panel_lat(panel_lat), .panel_oe(panel_oe),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rd_data <= mem[rd_address];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int plen(input int p);
    return 130 + (BT << p);
  endfunction

  function automatic logic [2:0] bits3(input logic [11:0] px, input int p);
    return {px[p], px[4 + p], px[8 + p]};
  endfunction

  task automatic check_cycle(input int t);
    int f, r, o, p, c, ph;
    logic [5:0] ce;
    logic dc;
    f = t % FRAME;
    r = f / ROWC;
    o = f % ROWC;
    p = 0;
    while (o >= plen(p)) begin
      o -= plen(p);
      p++;
    end
    chk($sformatf("frame_done t=%0d", t), frame_done, (t > 0 && f == 0));
    dc = 1'b1;
    c = 31;
    if (o < 128) begin
      c  = o / 4;
      ph = o % 4;
      chk($sformatf("oe t=%0d", t), panel_oe, 1);
      chk($sformatf("lat t=%0d", t), panel_lat, 0);
      chk($sformatf("pclk t=%0d", t), panel_clk, ph == 3);
      if (ph == 0)
        chk($sformatf("addr_up t=%0d", t), rd_address, r * 32 + c);
      if (ph == 1)
        chk($sformatf("addr_lo t=%0d", t), rd_address, (r + 16) * 32 + c);
      if (ph != 3) begin
        if (c == 0) dc = 1'b0;
        else c = c - 1;
      end
    end else begin
      chk($sformatf("pclk t=%0d", t), panel_clk, 0);
      chk($sformatf("lat t=%0d", t), panel_lat, o == 129);
      chk($sformatf("oe t=%0d", t), panel_oe, o == 128 || o == 129);
      if (o >= 129)
        chk($sformatf("row_addr t=%0d", t), row_addr, r);
    end
    if (dc) begin
      ce = {bits3(mem[r * 32 + c], p), bits3(mem[(r + 16) * 32 + c], p)};
      chk($sformatf("colour t=%0d r=%0d p=%0d c=%0d", t, r, p, c),
          {r1, g1, b1, r2, g2, b2}, ce);
    end
  endtask

  task automatic run(input int t0, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_cycle(t0 + i);
    end
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, " oe"}, panel_oe, 1);
    chk({tag, " pclk"}, panel_clk, 0);
    chk({tag, " lat"}, panel_lat, 0);
    chk({tag, " addr"}, rd_address, 0);
    chk({tag, " row_addr"}, row_addr, 0);
    chk({tag, " colour"}, {r1, g1, b1, r2, g2, b2}, 0);
    chk({tag, " frame_done"}, frame_done, 0);
  endtask

  task automatic idle_run(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      idle_chk(tag);
    end
  endtask

  int tdrop, tend;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 12'($urandom);
    mem[0]   = 12'hF0A;
    mem[512] = 12'h005;

    repeat (3) @(negedge clk);
    idle_chk("reset");
    rst = 1'b1;
    idle_run("idle", 100);

    enable = 1'b1;
    run(0, FRAME + 200);

    tdrop = FRAME + 3 * ROWC + plen(0) + 50;
    tend  = FRAME + 3 * ROWC + plen(0) + plen(1);
    run(FRAME + 200, tdrop - (FRAME + 200));
    enable = 1'b0;
    run(tdrop, tend - tdrop);
    idle_run("drop_idle", 20);

    enable = 1'b1;
    run(0, 330);
    chk("oe_before_rst", panel_oe, 0);
    #2;
    rst = 1'b0;
    #1;
    idle_chk("async_rst");
    @(negedge clk);
    rst = 1'b1;
    run(0, 200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hub75_scan.md
Name: hub75_scan

Overview:
- Display-side consumer of the 1024x12 pixel buffer that the SDRAM DMA stage fills.
- Reads pixels through the buffer's read port and drives a 32x32, 1/16-scan HUB75 LED panel.
- Uses 4-bit binary-coded modulation per colour, so each of the 16 row pairs is shown as 4 weighted bitplanes.
- Pulses frame_done once per full refresh so software can time the next DMA start.

Parameters:
- COLS, 32, pixels per row; row stride in the buffer.
- ROW_PAIRS, 16, row pairs; lower half row = upper row + ROW_PAIRS.
- BASE_TIME, 64, OE-low cycles for bitplane 0; plane b lasts BASE_TIME<<b cycles.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  run scanning while high.
- rd_address  out  10  buffer read address = row*COLS + col.
- rd_data  in  12  buffer read data, valid 1 cycle after rd_address. Bits [3:0]=R, [7:4]=G, [11:8]=B.
- r1, g1, b1  out  1 each  upper-half colour bits.
- r2, g2, b2  out  1 each  lower-half colour bits.
- row_addr  out  4  HUB75 A..D row-pair select.
- panel_clk  out  1  HUB75 shift clock; panel samples on rising edge.
- panel_lat  out  1  HUB75 latch, active high.
- panel_oe  out  1  HUB75 output enable, active low (1 = blank).
- frame_done  out  1  1-cycle pulse at the end of the last plane of row pair 15.

Behaviour:
- Reset (async, rst=0): rd_address=0, colour outputs=0, row_addr=0, panel_clk=0, panel_lat=0, panel_oe=1, frame_done=0. State=IDLE, row=0, plane=0, col=0. Applies immediately, including mid-shift or mid-display.
- IDLE: outputs hold their reset values. Moves to SHIFT when enable=1.
- SHIFT: 4-cycle phase per column, col 0..31, panel_oe=1 throughout.
  - P0: rd_address = row*32+col; panel_clk=0.
  - P1: capture upper pixel bit [plane] of R/G/B. rd_address = (row+16)*32+col.
  - P2: capture lower pixel bits. Register all six colour outputs together; panel_clk stays 0.
  - P3: panel_clk=1; colour outputs stable.
  - After col 31 P3, go to BLANK. Total 128 cycles per plane.
- BLANK (1 cycle): panel_clk=0, panel_oe=1, row_addr updated to the current row.
- LATCH (1 cycle): panel_lat=1, panel_oe=1.
- DISPLAY: panel_oe=0 for exactly BASE_TIME<<plane cycles; panel_lat=0. Display counter width is sized for BASE_TIME<<3. At end:
  - plane<3: plane+1, back to SHIFT.
  - plane=3: plane=0, row+1. If row was 15, row wraps to 0 and frame_done pulses in the first cycle after DISPLAY.
  - If enable=0 at DISPLAY end: go to IDLE with row=0, plane=0, panel_oe=1.
- enable is sampled only at IDLE and at DISPLAY end. Dropping it mid-plane has no effect until the plane finishes.
- Timing per plane: 130 + BASE_TIME<<plane cycles. Per row pair: 520 + 15*BASE_TIME cycles (1480 at default). Per frame: 23680 cycles at default.
- Colour mapping: r=bit[plane], g=bit[4+plane], b=bit[8+plane] of the pixel.
- No write arbitration; buffer writes during a scan may tear, which is accepted.

Test Plan:
- Reset/idle: rst=0 then 1 with enable=0 for 100 cycles -> panel_oe=1, panel_clk=0, panel_lat=0, rd_address=0 throughout.
- Colour decode: buf[0]=12'hF0A, buf[512]=12'h005, enable=1. At col 0 across planes 0..3: r1=0,1,0,1; g1=0 always; b1=1 always; r2=1,0,1,0; g2=b2=0.
- Address sequence: first plane issues rd_address 0,512,1,513,...,31,543, one address per 2 cycles inside each 4-cycle column phase. Exactly 32 panel_clk rising edges before panel_lat.
- Timing: BASE_TIME=64 -> panel_oe low for 64/128/256/512 consecutive cycles on planes 0..3. row_addr steps 0..15 and wraps. frame_done pulses once every 23680 cycles.
- Enable drop: deassert enable during plane 1 SHIFT of row 3 -> planes 1 DISPLAY (128 cycles) completes, then IDLE with panel_oe=1. Re-enable -> restart at row 0, plane 0 (rd_address=0).
- Async reset mid-DISPLAY: assert rst with panel_oe=0 -> panel_oe goes 1 without waiting for a clock edge. After release, the scan restarts at row 0.
